// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the async instruction memory and
// presents one registered {pc, instr} entry to decode over a valid/ready handshake.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_instr,
    output logic              misalign_err,
    output logic [31:0]       fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic [31:0] r_fetch_count;
    logic        r_if_valid;
    logic        r_misalign_err;

    logic        w_accept;
    logic        w_fetch;

    // The output entry can take a new word when empty or when decode drains it this cycle.
    assign w_accept = ~r_if_valid | if_ready;
    assign w_fetch  = w_accept & ~stall & ~redirect_valid;

    assign imem_addr    = r_pc[ADDR_W+1:2];
    assign if_valid     = r_if_valid;
    assign if_pc        = r_if_pc;
    assign if_instr     = r_if_instr;
    assign misalign_err = r_misalign_err;
    assign fetch_count  = r_fetch_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_if_valid     <= 1'b0;
            r_if_pc        <= 32'd0;
            r_if_instr     <= 32'd0;
            r_misalign_err <= 1'b0;
            r_fetch_count  <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments, so every branch below sees pre-edge state.
            if (r_if_valid && if_ready) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            if (redirect_valid) begin
                // A handshake in the same cycle still counts, but the entry is flushed.
                r_pc           <= {redirect_pc[31:2], 2'b00};
                r_if_valid     <= 1'b0;
                r_misalign_err <= r_misalign_err | (redirect_pc[1:0] != 2'b00);
            end else if (w_fetch) begin
                r_if_pc    <= r_pc;
                r_if_instr <= imem_data;
                r_if_valid <= 1'b1;
                r_pc       <= r_pc + 32'd4;
            end else if (stall && r_if_valid && if_ready) begin
                r_if_valid <= 1'b0;
            end
        end
    end

endmodule
